// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multicycle MIPS-subset controller with req/ready memory handshakes,
//            wait watchdog, illegal-opcode policy and retired-instruction count.
// Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int CNT_W           = 5,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int RET_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       op,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             ExtSel,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             WrRegDSrc,
    output logic             ALUM2Reg,
    output logic             RD,
    output logic             WR,
    output logic             InsMemRW,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUCtrl,
    output logic [2:0]       state,
    output logic             err,
    output logic [RET_W-1:0] retired
);

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_ADDI = 6'b000010;
    localparam logic [5:0] c_OP_OR   = 6'b010000;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_ORI  = 6'b010010;
    localparam logic [5:0] c_OP_SLL  = 6'b011000;
    localparam logic [5:0] c_OP_SLT  = 6'b100111;
    localparam logic [5:0] c_OP_SW   = 6'b110000;
    localparam logic [5:0] c_OP_LW   = 6'b110001;
    localparam logic [5:0] c_OP_BEQ  = 6'b110100;
    localparam logic [5:0] c_OP_J    = 6'b111000;
    localparam logic [5:0] c_OP_JR   = 6'b111001;
    localparam logic [5:0] c_OP_JAL  = 6'b111010;
    localparam logic [5:0] c_OP_HALT = 6'b111111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_SLL = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_AND = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    localparam logic [1:0] c_PC_INC    = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_RS     = 2'b10;
    localparam logic [1:0] c_PC_JUMP   = 2'b11;

    localparam logic [1:0] c_DST_RA = 2'b00;
    localparam logic [1:0] c_DST_RT = 2'b01;
    localparam logic [1:0] c_DST_RD = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101,
        S_ERR  = 3'b110
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_waitCnt;
    logic [RET_W-1:0]   r_retired;
    logic               w_timeout;

    // Opcode decode
    logic       w_legal;
    logic       w_isRType;
    logic       w_isImm;
    logic       w_signExt;
    logic       w_isLoad;
    logic       w_isStore;
    logic       w_isBeq;
    logic       w_isSll;
    logic       w_isJ;
    logic       w_isJr;
    logic       w_isJal;
    logic       w_isHalt;
    logic [2:0] w_aluOp;

    // Ungated strobes
    logic       w_imemReq;
    logic       w_dmemReq;
    logic       w_pcWre;
    logic       w_irWre;
    logic       w_regWre;
    logic       w_extSel;
    logic       w_aluSrcA;
    logic       w_aluSrcB;
    logic       w_wrRegDSrc;
    logic       w_aluM2Reg;
    logic       w_rd;
    logic       w_wr;
    logic [1:0] w_regDst;
    logic [1:0] w_pcSrc;
    logic [2:0] w_aluCtrl;

    always_comb begin
        w_legal   = 1'b1;
        w_isRType = 1'b0;
        w_isImm   = 1'b0;
        w_signExt = 1'b0;
        w_isLoad  = 1'b0;
        w_isStore = 1'b0;
        w_isBeq   = 1'b0;
        w_isSll   = 1'b0;
        w_isJ     = 1'b0;
        w_isJr    = 1'b0;
        w_isJal   = 1'b0;
        w_isHalt  = 1'b0;
        w_aluOp   = c_ALU_ADD;
        case (op)
            c_OP_ADD:  w_isRType = 1'b1;
            c_OP_SUB:  begin w_isRType = 1'b1; w_aluOp = c_ALU_SUB; end
            c_OP_ADDI: begin w_isImm = 1'b1; w_signExt = 1'b1; end
            c_OP_OR:   begin w_isRType = 1'b1; w_aluOp = c_ALU_OR; end
            c_OP_AND:  begin w_isRType = 1'b1; w_aluOp = c_ALU_AND; end
            c_OP_ORI:  begin w_isImm = 1'b1; w_aluOp = c_ALU_OR; end
            c_OP_SLL:  begin w_isRType = 1'b1; w_isSll = 1'b1; w_aluOp = c_ALU_SLL; end
            c_OP_SLT:  begin w_isRType = 1'b1; w_aluOp = c_ALU_SLT; end
            c_OP_SW:   begin w_isImm = 1'b1; w_signExt = 1'b1; w_isStore = 1'b1; end
            c_OP_LW:   begin w_isImm = 1'b1; w_signExt = 1'b1; w_isLoad = 1'b1; end
            c_OP_BEQ:  begin w_signExt = 1'b1; w_isBeq = 1'b1; w_aluOp = c_ALU_SUB; end
            c_OP_J:    w_isJ = 1'b1;
            c_OP_JR:   w_isJr = 1'b1;
            c_OP_JAL:  w_isJal = 1'b1;
            c_OP_HALT: w_isHalt = 1'b1;
            default:   w_legal = 1'b0;
        endcase
    end

    // Watchdog fires on the last allowed wait cycle unless ready arrives then.
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_watchdog
            localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            assign w_timeout = (r_waitCnt == c_WAIT_LAST);
        end else begin : g_noWatchdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next      = r_state;
        w_imemReq   = 1'b0;
        w_dmemReq   = 1'b0;
        w_pcWre     = 1'b0;
        w_irWre     = 1'b0;
        w_regWre    = 1'b0;
        w_extSel    = 1'b0;
        w_aluSrcA   = 1'b0;
        w_aluSrcB   = 1'b0;
        w_wrRegDSrc = 1'b0;
        w_aluM2Reg  = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_regDst    = c_DST_RA;
        w_pcSrc     = c_PC_INC;
        w_aluCtrl   = c_ALU_ADD;
        case (r_state)
            S_IF: begin
                w_imemReq = 1'b1;
                if (imem_ready) begin
                    w_irWre = 1'b1;
                    w_next  = S_ID;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_ID: begin
                if (w_isJ) begin
                    w_pcWre = 1'b1;
                    w_pcSrc = c_PC_JUMP;
                    w_next  = S_IF;
                end else if (w_isJr) begin
                    w_pcWre = 1'b1;
                    w_pcSrc = c_PC_RS;
                    w_next  = S_IF;
                end else if (w_isJal) begin
                    w_pcWre     = 1'b1;
                    w_pcSrc     = c_PC_JUMP;
                    w_regWre    = 1'b1;
                    w_regDst    = c_DST_RA;
                    w_wrRegDSrc = 1'b0;
                    w_next      = S_IF;
                end else if (w_isHalt) begin
                    w_next = S_HALT;
                end else if (!w_legal) begin
                    if (HALT_ON_ILLEGAL) begin
                        w_next = S_ERR;
                    end else begin
                        w_pcWre = 1'b1;
                        w_pcSrc = c_PC_INC;
                        w_next  = S_IF;
                    end
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                w_aluSrcA = w_isSll;
                w_aluSrcB = w_isImm;
                w_extSel  = w_signExt;
                w_aluCtrl = w_aluOp;
                if (w_isBeq) begin
                    w_pcWre = 1'b1;
                    w_pcSrc = Zero ? c_PC_BRANCH : c_PC_INC;
                    w_next  = S_IF;
                end else if (w_isLoad || w_isStore) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dmemReq  = 1'b1;
                w_rd       = w_isLoad;
                w_wr       = w_isStore;
                w_aluM2Reg = w_isLoad;
                if (dmem_ready) begin
                    if (w_isStore) begin
                        w_pcWre = 1'b1;
                        w_pcSrc = c_PC_INC;
                        w_next  = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                w_regWre    = 1'b1;
                w_wrRegDSrc = 1'b1;
                w_pcWre     = 1'b1;
                w_pcSrc     = c_PC_INC;
                w_regDst    = w_isRType ? c_DST_RD : c_DST_RT;
                w_aluM2Reg  = w_isLoad;
                w_next      = S_IF;
            end
            default: begin
                w_next = r_state;
            end
        endcase
    end

    // Requests and write strobes drop the instant reset asserts.
    assign imem_req  = RST & w_imemReq;
    assign dmem_req  = RST & w_dmemReq;
    assign PCWre     = RST & w_pcWre;
    assign IRWre     = RST & w_irWre;
    assign RegWre    = RST & w_regWre;
    assign RD        = RST & w_rd;
    assign WR        = RST & w_wr;
    assign ExtSel    = w_extSel;
    assign ALUSrcA   = w_aluSrcA;
    assign ALUSrcB   = w_aluSrcB;
    assign WrRegDSrc = w_wrRegDSrc;
    assign ALUM2Reg  = w_aluM2Reg;
    assign RegDst    = w_regDst;
    assign PCSrc     = w_pcSrc;
    assign ALUCtrl   = w_aluCtrl;
    assign InsMemRW  = 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IF;
            r_waitCnt <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_waitCnt <= '0;
            end else if ((r_state == S_IF) || (r_state == S_MEM)) begin
                r_waitCnt <= r_waitCnt + CNT_W'(1);
            end
            if (w_pcWre) begin
                r_retired <= r_retired + RET_W'(1);
            end
        end
    end

    assign state   = r_state;
    assign err     = (r_state == S_ERR);
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Two controller instances (different watchdog / illegal policies)
//            driven in lockstep and compared against an instruction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

    logic       CLK;
    logic       RST;
    logic [5:0] op;
    logic       Zero;
    logic       imem_ready;
    logic       dmem_ready;

    logic [1:0]       imemReq, dmemReq, pcWre, irWre, regWre, extSel, aluSrcA, aluSrcB;
    logic [1:0]       wrRegDSrc, aluM2Reg, rdS, wrS, insMemRW, errO;
    logic [1:0][1:0]  regDst, pcSrc;
    logic [1:0][2:0]  aluCtrl, stateO;
    logic [1:0][31:0] retiredO;

    mc_control_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(5), .HALT_ON_ILLEGAL(1'b1), .RET_W(32)) u_dutA (
        .CLK(CLK), .RST(RST), .op(op), .Zero(Zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imemReq[0]), .dmem_req(dmemReq[0]), .PCWre(pcWre[0]), .IRWre(irWre[0]),
        .RegWre(regWre[0]), .ExtSel(extSel[0]), .ALUSrcA(aluSrcA[0]), .ALUSrcB(aluSrcB[0]),
        .WrRegDSrc(wrRegDSrc[0]), .ALUM2Reg(aluM2Reg[0]), .RD(rdS[0]), .WR(wrS[0]),
        .InsMemRW(insMemRW[0]), .RegDst(regDst[0]), .PCSrc(pcSrc[0]), .ALUCtrl(aluCtrl[0]),
        .state(stateO[0]), .err(errO[0]), .retired(retiredO[0])
    );

    mc_control_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(3), .HALT_ON_ILLEGAL(1'b0), .RET_W(32)) u_dutB (
        .CLK(CLK), .RST(RST), .op(op), .Zero(Zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imemReq[1]), .dmem_req(dmemReq[1]), .PCWre(pcWre[1]), .IRWre(irWre[1]),
        .RegWre(regWre[1]), .ExtSel(extSel[1]), .ALUSrcA(aluSrcA[1]), .ALUSrcB(aluSrcB[1]),
        .WrRegDSrc(wrRegDSrc[1]), .ALUM2Reg(aluM2Reg[1]), .RD(rdS[1]), .WR(wrS[1]),
        .InsMemRW(insMemRW[1]), .RegDst(regDst[1]), .PCSrc(pcSrc[1]), .ALUCtrl(aluCtrl[1]),
        .state(stateO[1]), .err(errO[1]), .retired(retiredO[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nVectors = 0;
    int nMiscompares = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Instruction attributes straight from the opcode table
    typedef struct packed {
        logic       legal, rtype, imm, sext, load, store, branch, sll, j, jr, jal, halt;
        logic [2:0] alu;
    } attr_t;

    function automatic attr_t decode(input logic [5:0] o);
        attr_t a;
        a = '0;
        a.legal = 1'b1;
        case (o)
            6'b000000: a.rtype = 1'b1;
            6'b000001: begin a.rtype = 1'b1; a.alu = 3'd1; end
            6'b000010: begin a.imm = 1'b1; a.sext = 1'b1; end
            6'b010000: begin a.rtype = 1'b1; a.alu = 3'd3; end
            6'b010001: begin a.rtype = 1'b1; a.alu = 3'd4; end
            6'b010010: begin a.imm = 1'b1; a.alu = 3'd3; end
            6'b011000: begin a.rtype = 1'b1; a.sll = 1'b1; a.alu = 3'd2; end
            6'b100111: begin a.rtype = 1'b1; a.alu = 3'd5; end
            6'b110000: begin a.imm = 1'b1; a.sext = 1'b1; a.store = 1'b1; end
            6'b110001: begin a.imm = 1'b1; a.sext = 1'b1; a.load = 1'b1; end
            6'b110100: begin a.sext = 1'b1; a.branch = 1'b1; a.alu = 3'd1; end
            6'b111000: a.j = 1'b1;
            6'b111001: a.jr = 1'b1;
            6'b111010: a.jal = 1'b1;
            6'b111111: a.halt = 1'b1;
            default:   a.legal = 1'b0;
        endcase
        return a;
    endfunction

    // Phase numbers are the state codes: 0 IF,1 ID,2 EXE,3 MEM,4 WB,5 HALT,6 ERR
    function automatic void refModel(input int ph, input logic [5:0] o, input logic z,
                                     input logic ir, input logic dr, input int cnt,
                                     input int tmo, input bit haltIll, input bit rn,
                                     output logic [23:0] ev, output int nph);
        attr_t a;
        logic iq, dq, pcw, irw, rw, ext, asa, asb, wrs, m2r, rd, wr;
        logic [1:0] rdst, psrc;
        logic [2:0] alu;
        bit expired;
        a = decode(o);
        {iq, dq, pcw, irw, rw, ext, asa, asb, wrs, m2r, rd, wr} = '0;
        rdst = 2'b00; psrc = 2'b00; alu = 3'b000;
        expired = (tmo != 0) && (cnt == tmo - 1);
        nph = ph;
        case (ph)
            0: begin
                iq = 1'b1;
                if (ir) begin irw = 1'b1; nph = 1; end
                else if (expired) nph = 6;
            end
            1: begin
                if (a.j || a.jr || a.jal) begin
                    pcw = 1'b1; psrc = a.jr ? 2'b10 : 2'b11; rw = a.jal; nph = 0;
                end else if (a.halt) nph = 5;
                else if (!a.legal) begin
                    if (haltIll) nph = 6;
                    else begin pcw = 1'b1; nph = 0; end
                end else nph = 2;
            end
            2: begin
                asa = a.sll; asb = a.imm; ext = a.sext; alu = a.alu;
                if (a.branch) begin pcw = 1'b1; psrc = {1'b0, z}; nph = 0; end
                else nph = (a.load || a.store) ? 3 : 4;
            end
            3: begin
                dq = 1'b1; rd = a.load; wr = a.store; m2r = a.load;
                if (dr) begin
                    if (a.store) begin pcw = 1'b1; nph = 0; end
                    else nph = 4;
                end else if (expired) nph = 6;
            end
            4: begin
                rw = 1'b1; wrs = 1'b1; pcw = 1'b1; m2r = a.load;
                rdst = a.rtype ? 2'b10 : 2'b01; nph = 0;
            end
            default: nph = ph;
        endcase
        if (!rn) {iq, dq, pcw, irw, rw, rd, wr} = '0;
        ev = {iq, dq, pcw, irw, rw, ext, asa, asb, wrs, m2r, rd, wr, 1'b1,
              rdst, psrc, alu, 3'(ph), (ph == 6)};
    endfunction

    int          ph [2];
    int          cnt [2];
    logic [31:0] ret [2];
    logic [23:0] expV [2];
    int          nph [2];
    int          tmo [2] = '{16, 4};
    bit          hil [2] = '{1'b1, 1'b0};

    function automatic logic [23:0] packOut(input int m);
        return {imemReq[m], dmemReq[m], pcWre[m], irWre[m], regWre[m], extSel[m], aluSrcA[m],
                aluSrcB[m], wrRegDSrc[m], aluM2Reg[m], rdS[m], wrS[m], insMemRW[m],
                regDst[m], pcSrc[m], aluCtrl[m], stateO[m], errO[m]};
    endfunction

    // One clock: drive just after posedge, check at negedge, advance model at posedge.
    task automatic step(input logic [5:0] o, input logic z, input logic ir, input logic dr, input logic rn);
        op = o; Zero = z; imem_ready = ir; dmem_ready = dr; RST = rn;
        if (!rn) begin
            for (int m = 0; m < 2; m++) begin ph[m] = 0; cnt[m] = 0; ret[m] = '0; end
        end
        @(negedge CLK);
        for (int m = 0; m < 2; m++) begin
            refModel(ph[m], o, z, ir, dr, cnt[m], tmo[m], hil[m], rn, expV[m], nph[m]);
            checkVal(m == 0 ? "A.strobes" : "B.strobes", 64'(packOut(m)), 64'(expV[m]));
            checkVal(m == 0 ? "A.retired" : "B.retired", 64'(retiredO[m]), 64'(ret[m]));
        end
        @(posedge CLK);
        if (rn) begin
            for (int m = 0; m < 2; m++) begin
                if (expV[m][21]) ret[m] = ret[m] + 32'd1;
                if (nph[m] != ph[m]) cnt[m] = 0;
                else if (ph[m] == 0 || ph[m] == 3) cnt[m] = cnt[m] + 1;
                ph[m] = nph[m];
            end
        end
        #1;
    endtask

    task automatic runInstr(input logic [5:0] o, input logic z, input int iDelay, input int dDelay);
        int memCycles;
        logic d;
        memCycles = 0;
        for (int i = 0; i < iDelay; i++) step(o, z, 1'b0, 1'b0, 1'b1);
        step(o, z, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 30 && !(ph[0] == 0 || ph[0] >= 5); i++) begin
            d = (ph[0] == 3) && (memCycles >= dDelay);
            if (ph[0] == 3) memCycles++;
            step(o, z, 1'b0, d, 1'b1);
        end
    endtask

    logic [5:0] legalOps [14] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                  6'b010010, 6'b011000, 6'b100111, 6'b110000, 6'b110001,
                                  6'b110100, 6'b111000, 6'b111001, 6'b111010};

    function automatic logic [5:0] pickOp();
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)  return 6'b111111;
        if (r < 15) return 6'($urandom_range(0, 63));
        return legalOps[$urandom_range(0, 13)];
    endfunction

    initial begin
        logic [31:0] retB;
        logic [5:0]  curOp;
        logic        rn;
        int          stuck;
        RST = 1'b0; op = '0; Zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        for (int m = 0; m < 2; m++) begin ph[m] = 0; cnt[m] = 0; ret[m] = '0; end
        @(posedge CLK); #1;

        step(6'b000000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("rst.state", 64'(stateO[0]), 64'd0);
        checkVal("rst.imem_req", 64'(imemReq[0]), 64'd0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        runInstr(6'b000000, 1'b0, 0, 0);                     // ADD
        checkVal("add.retired", 64'(retiredO[0]), 64'd1);
        runInstr(6'b110001, 1'b0, 3, 2);                     // LW, delayed memories
        checkVal("lw.retired", 64'(retiredO[0]), 64'd2);
        runInstr(6'b110100, 1'b1, 0, 0);                     // BEQ taken
        runInstr(6'b110100, 1'b0, 0, 0);                     // BEQ not taken
        runInstr(6'b111010, 1'b0, 0, 0);                     // JAL
        checkVal("jal.retired", 64'(retiredO[0]), 64'd5);

        runInstr(6'b110000, 1'b0, 0, 4);                     // SW: B times out, A completes
        checkVal("tmo.B.state", 64'(stateO[1]), 64'd6);
        checkVal("tmo.B.err", 64'(errO[1]), 64'd1);
        checkVal("tmo.B.WR", 64'(wrS[1]), 64'd0);
        for (int i = 0; i < 3; i++) step(6'b110000, 1'b0, 1'b1, 1'b1, 1'b1);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("tmo.rst.state", 64'(stateO[1]), 64'd0);
        checkVal("tmo.rst.retired", 64'(retiredO[1]), 64'd0);

        retB = ret[1];
        runInstr(6'b101010, 1'b0, 0, 0);                     // illegal opcode
        checkVal("ill.A.state", 64'(stateO[0]), 64'd6);
        checkVal("ill.B.retired", 64'(retiredO[1]), 64'(retB + 32'd1));
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        runInstr(6'b111111, 1'b0, 0, 0);                     // HALT
        checkVal("halt.state", 64'(stateO[0]), 64'd5);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) step(6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("ifTmo.A.state", 64'(stateO[0]), 64'd6);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-handshake while a store is waiting in MEM
        runInstr(6'b110000, 1'b0, 0, 0);
        step(6'b110000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(6'b110000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'b110000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'b110000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("midRst.WR", 64'(wrS[0]), 64'd0);

        curOp = 6'b000000;
        stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            if (ph[0] == 0 || ph[0] >= 5) curOp = pickOp();
            rn = 1'b1;
            if (ph[0] >= 5 || ph[1] >= 5) stuck++;
            else stuck = 0;
            if (stuck > 6 || $urandom_range(0, 149) == 0) begin rn = 1'b0; stuck = 0; end
            step(curOp, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 5), rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
`default_nettype wire
